fir_hls_sdiv_43s_11s_32_seq: RTL and testbench

//  Sequential signed divider; the inverse of the FIR 32s x 11s -> 43s tap multiplier.

---
 rtl/fir_hls_sdiv_43s_11s_32_seq_if.sv | 27 ++
 rtl/fir_hls_sdiv_43s_11s_32_seq.sv | 112 +++++++++++
 tb/tb_fir_hls_sdiv_43s_11s_32_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fir_hls_sdiv_43s_11s_32_seq_if.sv
// fir_hls_sdiv_43s_11s_32_seq_if: operand/result handshake bundle for the sequential signed divider
interface fir_hls_sdiv_43s_11s_32_seq_if #(
    parameter int DIVIDEND_W = 43,
    parameter int DIVISOR_W  = 11,
    parameter int QUOT_W     = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic                  out_valid;
    logic                  out_ready;
    logic [QUOT_W-1:0]     quotient;
    logic [DIVISOR_W-1:0]  remainder;
    logic                  div_by_zero;
    logic                  overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/fir_hls_sdiv_43s_11s_32_seq.sv
// fir_hls_sdiv_43s_11s_32_seq: radix-2 non-restoring signed divider, 43s / 11s -> 32s with saturation
module fir_hls_sdiv_43s_11s_32_seq #(
    parameter int DIVIDEND_W = 43,
    parameter int DIVISOR_W  = 11,
    parameter int QUOT_W     = 32
) (
    input  logic ap_clk,
    input  logic ap_rst,
    fir_hls_sdiv_43s_11s_32_seq_if.slave s
);
    // Partial remainder stays within [-|d|, |d|) with |d| <= 2^(DIVISOR_W-1); two guard bits cover 2P+bit.
    localparam int PW = DIVISOR_W + 2;
    localparam int CW = $clog2(DIVIDEND_W);
    localparam logic [DIVIDEND_W-1:0] QMAX  = DIVIDEND_W'({(QUOT_W-1){1'b1}});
    localparam logic [QUOT_W-1:0]     SAT_P = {1'b0, {(QUOT_W-1){1'b1}}};
    localparam logic [QUOT_W-1:0]     SAT_N = {1'b1, {(QUOT_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                r_state, w_next;
    logic [CW-1:0]         r_cnt;
    logic [DIVIDEND_W-1:0] r_a;
    logic [DIVISOR_W:0]    r_b;
    logic [PW-1:0]         r_p;
    logic                  r_qneg, r_rneg;
    logic [QUOT_W-1:0]     r_quot;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  r_dbz, r_ovf;

    logic                  w_dz;
    logic [DIVIDEND_W-1:0] w_a_abs, w_qs;
    logic [DIVISOR_W:0]    w_b_abs;
    logic [PW-1:0]         w_bx, w_p2, w_pn, w_r_mag;
    logic                  w_ovf;

    // The unsigned magnitude of any 43-bit signed value, including -2^42, fits in 43 bits.
    assign w_dz    = s.divisor == '0;
    assign w_a_abs = s.dividend[DIVIDEND_W-1] ? -s.dividend : s.dividend;
    assign w_b_abs = s.divisor[DIVISOR_W-1] ? -{1'b1, s.divisor} : {1'b0, s.divisor};
    assign w_bx    = {{(PW-DIVISOR_W-1){1'b0}}, r_b};
    // Shift in the next dividend bit, then subtract or add the divisor by the current remainder sign.
    assign w_p2    = {r_p[PW-2:0], r_a[DIVIDEND_W-1]};
    assign w_pn    = r_p[PW-1] ? w_p2 + w_bx : w_p2 - w_bx;
    // A negative final partial remainder needs one restoring add.
    assign w_r_mag = r_p[PW-1] ? r_p + w_bx : r_p;
    assign w_qs    = r_qneg ? -r_a : r_a;
    assign w_ovf   = r_a > (r_qneg ? QMAX + 1'b1 : QMAX);

    assign s.in_ready    = r_state == IDLE;
    assign s.out_valid   = r_state == DONE;
    assign s.quotient    = r_quot;
    assign s.remainder   = r_rem;
    assign s.div_by_zero = r_dbz;
    assign s.overflow    = r_ovf;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic: accept, iterate, correct, hold the result until taken.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (s.in_valid) w_next = w_dz ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_next = FIX;
            FIX:     w_next = DONE;
            DONE:    if (s.out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath: operand capture, one quotient bit per CALC cycle, sign/saturation in FIX.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_quot <= '0;
            r_rem  <= '0;
            r_dbz  <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (s.in_valid) begin
                    r_a    <= w_a_abs;
                    r_b    <= w_b_abs;
                    r_p    <= '0;
                    r_cnt  <= CW'(DIVIDEND_W - 1);
                    r_qneg <= s.dividend[DIVIDEND_W-1] ^ s.divisor[DIVISOR_W-1];
                    r_rneg <= s.dividend[DIVIDEND_W-1];
                    if (w_dz) begin
                        r_quot <= s.dividend[DIVIDEND_W-1] ? SAT_N : SAT_P;
                        r_rem  <= '0;
                        r_dbz  <= 1'b1;
                        r_ovf  <= 1'b0;
                    end
                end
                CALC: begin
                    r_p   <= w_pn;
                    r_a   <= {r_a[DIVIDEND_W-2:0], ~w_pn[PW-1]};
                    r_cnt <= r_cnt - 1'b1;
                end
                FIX: begin
                    r_quot <= w_ovf ? (r_qneg ? SAT_N : SAT_P) : QUOT_W'(w_qs);
                    r_rem  <= DIVISOR_W'(r_rneg ? -w_r_mag : w_r_mag);
                    r_dbz  <= 1'b0;
                    r_ovf  <= w_ovf;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_hls_sdiv_43s_11s_32_seq.sv
// tb_fir_hls_sdiv_43s_11s_32_seq: randomized self-checking bench against an arithmetic reference model
module tb_fir_hls_sdiv_43s_11s_32_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    fir_hls_sdiv_43s_11s_32_seq_if bus ();

    fir_hls_sdiv_43s_11s_32_seq dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .s      (bus)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic void model(input longint a, input longint b, output longint q, output longint r,
                                  output bit dz, output bit ov);
        longint t;
        if (b == 0) begin
            dz = 1'b1;
            ov = 1'b0;
            r  = 0;
            q  = (a >= 0) ? 64'sd2147483647 : -64'sd2147483648;
        end else begin
            t  = a / b;
            r  = a % b;
            dz = 1'b0;
            ov = (t > 64'sd2147483647) || (t < -64'sd2147483648);
            q  = (t > 64'sd2147483647) ? 64'sd2147483647 : (t < -64'sd2147483648) ? -64'sd2147483648 : t;
        end
    endfunction

    task automatic do_op(input longint a, input longint b, input int hold);
        longint eq, er;
        bit     ed, eo;
        int     lat;
        model(a, b, eq, er, ed, eo);
        @(negedge clk);
        chk("in_ready_idle", 64'(bus.in_ready), 64'sd1);
        bus.dividend = a[42:0];
        bus.divisor  = b[10:0];
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = 43'({$urandom(), $urandom()});
        bus.divisor  = 11'($urandom());
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.out_valid && lat < 100);
        chk("latency", 64'(lat), ed ? 64'sd1 : 64'sd45);
        chk("quotient", 64'($signed(bus.quotient)), eq);
        chk("remainder", 64'($signed(bus.remainder)), er);
        chk("div_by_zero", 64'(bus.div_by_zero), 64'(ed));
        chk("overflow", 64'(bus.overflow), 64'(eo));
        chk("in_ready_done", 64'(bus.in_ready), 64'sd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'(bus.out_valid), 64'sd1);
            chk("hold_quotient", 64'($signed(bus.quotient)), eq);
            chk("hold_remainder", 64'($signed(bus.remainder)), er);
            chk("hold_in_ready", 64'(bus.in_ready), 64'sd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("valid_drop", 64'(bus.out_valid), 64'sd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        longint            qs [3];
        longint            cs [3];
        logic signed [42:0] rd;
        logic signed [19:0] sd;
        logic signed [10:0] rv;
        longint            a, b;
        int                seen;
        qs = '{64'sd2147483647, -64'sd2147483648, -64'sd12345};
        cs = '{-64'sd1024, 64'sd1023, -64'sd1};
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'sd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'sd1);
        chk("rst_quotient", 64'(bus.quotient), 64'sd0);
        chk("rst_remainder", 64'(bus.remainder), 64'sd0);
        chk("rst_div_by_zero", 64'(bus.div_by_zero), 64'sd0);
        chk("rst_overflow", 64'(bus.overflow), 64'sd0);

        do_op(-64'sd864197523, -64'sd7, 0);
        do_op(64'sd100, 64'sd7, 0);
        do_op(-64'sd100, 64'sd7, 0);
        do_op(64'sd100, -64'sd7, 0);
        do_op(-64'sd100, -64'sd7, 0);
        do_op(-64'sd2199023254528, -64'sd1024, 0);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                do_op(qs[i] * cs[j], cs[j], 0);
        do_op(64'sd1 << 40, 64'sd1, 0);
        do_op(-(64'sd1 << 42), 64'sd1, 0);
        do_op(-(64'sd1 << 42), -64'sd1, 0);
        do_op((64'sd1 << 42) - 1, -64'sd1024, 0);
        do_op(-64'sd5, 64'sd0, 0);
        do_op(64'sd5, 64'sd0, 0);
        do_op(64'sd100, 64'sd7, 10);

        @(negedge clk);
        bus.dividend = 43'd100;
        bus.divisor  = 11'd7;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_out_valid", 64'(bus.out_valid), 64'sd0);
        chk("mid_rst_in_ready", 64'(bus.in_ready), 64'sd1);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            seen |= int'(bus.out_valid);
        end
        chk("mid_rst_no_result", 64'(seen), 64'sd0);
        do_op(64'sd100, 64'sd7, 0);

        for (int n = 0; n < 40; n++) begin
            rd = 43'({$urandom(), $urandom()});
            sd = 20'($urandom());
            rv = 11'($urandom());
            a  = ($urandom_range(0, 1) == 0) ? longint'(rd) : longint'(sd);
            case ($urandom_range(0, 7))
                0:       b = 0;
                1:       b = ($urandom_range(0, 1) == 0) ? 64'sd1 : -64'sd1;
                2:       b = -64'sd1024;
                default: b = longint'(rv);
            endcase
            do_op(a, b, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
